// File: rtl/rmt_ctrl_pkg.sv
// rmt_ctrl_pkg: shared control-path constants, FSM state type and header packer (used by ctrl_pkt_gen and the stage-side parsers)
package rmt_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;
  localparam logic [2:0] RES_KEY_EXTRACT = 3'd0;
  localparam logic [2:0] RES_KEY_MASK = 3'd1;
  localparam logic [2:0] RES_CAM = 3'd2;
  localparam logic [2:0] RES_ACT_RAM = 3'd3;
  localparam int MAGIC_OFF = 0;
  localparam int MODID_OFF = 8;
  localparam int IDX_OFF = 16;
  localparam int SEQ_OFF = 24;
  localparam int NBEATS_OFF = 32;
  localparam int HDR_W = 40;
  localparam logic [7:0] CTRL_MAGIC_DEF = 8'hF2;
  function automatic logic [HDR_W-1:0] ctrl_hdr_pack(input logic [7:0] magic, input logic [4:0] stage,
                                                     input logic [2:0] res, input logic [7:0] idx,
                                                     input logic [7:0] seq, input logic [7:0] nbeats);
    ctrl_hdr_pack = '0;
    ctrl_hdr_pack[MAGIC_OFF +: 8] = magic;
    ctrl_hdr_pack[MODID_OFF +: 8] = {stage, res};
    ctrl_hdr_pack[IDX_OFF +: 8] = idx;
    ctrl_hdr_pack[SEQ_OFF +: 8] = seq;
    ctrl_hdr_pack[NBEATS_OFF +: 8] = nbeats;
  endfunction
endpackage

// File: rtl/ctrl_pkt_gen_if.sv
// ctrl_pkt_gen_if: config request handshake (cfg_*) plus control AXI-Stream (c_m_axis_*, no tready); master = packet generator side
interface ctrl_pkt_gen_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 128,
  parameter int MAX_BEATS = 2
);
  logic cfg_req_valid;
  logic cfg_req_ready;
  logic [4:0] cfg_stage_id;
  logic [2:0] cfg_res_id;
  logic [7:0] cfg_index;
  logic [1:0] cfg_nbeats;
  logic [MAX_BEATS*DATA_W-1:0] cfg_payload;
  logic [DATA_W-1:0] c_m_axis_tdata;
  logic [USER_W-1:0] c_m_axis_tuser;
  logic [DATA_W/8-1:0] c_m_axis_tkeep;
  logic c_m_axis_tvalid;
  logic c_m_axis_tlast;
  modport master (
    input cfg_req_valid, cfg_stage_id, cfg_res_id, cfg_index, cfg_nbeats, cfg_payload,
    output cfg_req_ready, c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast
  );
  modport slave (
    output cfg_req_valid, cfg_stage_id, cfg_res_id, cfg_index, cfg_nbeats, cfg_payload,
    input cfg_req_ready, c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast
  );
endinterface

// File: rtl/ctrl_pkt_gen.sv
// ctrl_pkt_gen: turns cfg writes into header+payload control beats with a forced idle gap; ports axis_clk, aresetn (sync, active-low), bus (ctrl_pkt_gen_if.master), busy, pkt_cnt
module ctrl_pkt_gen
  import rmt_ctrl_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int MAX_BEATS = 2,
  parameter int GAP_CYCLES = 2,
  parameter logic [7:0] CTRL_MAGIC = CTRL_MAGIC_DEF,
  parameter logic [7:0] SRC_PORT = 8'h00
) (
  input  logic axis_clk,
  input  logic aresetn,
  ctrl_pkt_gen_if.master bus,
  output logic busy,
  output logic [31:0] pkt_cnt
);
  localparam int W = C_S_AXIS_DATA_WIDTH;
  localparam int U = C_S_AXIS_TUSER_WIDTH;
  state_t r_state, w_next;
  logic [1:0] r_cnt, r_k, w_k_nxt, w_cnt_eff, w_ocnt;
  logic [7:0] r_seq, r_gap;
  logic [31:0] r_pkt_cnt;
  logic [MAX_BEATS*W-1:0] r_payload;
  logic w_accept, w_last, w_gap_done, w_data_beat, w_tvalid, w_tlast;
  logic [15:0] w_len;
  logic [W-1:0] w_tdata, r_tdata;
  logic [U-1:0] w_tuser, r_tuser;
  logic [W/8-1:0] w_tkeep, r_tkeep;
  logic r_tvalid, r_tlast;
  assign w_accept = r_state == IDLE && bus.cfg_req_valid;
  assign w_last = r_state == DATA && r_k == r_cnt - 2'd1;
  assign w_gap_done = 32'(r_gap) == GAP_CYCLES - 1;
  assign w_cnt_eff = bus.cfg_nbeats == 2'd0 ? 2'd1 :
                     32'(bus.cfg_nbeats) > MAX_BEATS ? 2'(MAX_BEATS) : bus.cfg_nbeats;
  assign w_k_nxt = r_state == HDR ? 2'd0 : r_k + 2'd1;
  always_ff @(posedge axis_clk) begin
    if (!aresetn) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE ? (bus.cfg_req_valid ? HDR : IDLE) :
             r_state == HDR  ? DATA :
             r_state == DATA ? (w_last ? (GAP_CYCLES == 0 ? IDLE : GAP) : DATA) :
             (w_gap_done ? IDLE : GAP);
  end
  // Outputs are computed for the beat of the next state so they can be registered
  // without adding a cycle; the header uses the live request inputs at accept.
  always_comb begin
    w_data_beat = w_next == DATA;
    w_tvalid = w_accept || w_data_beat;
    w_ocnt = w_accept ? w_cnt_eff : r_cnt;
    w_len = 16'((32'(w_ocnt) + 1) * W / 8);
    w_tdata = w_accept ? W'(ctrl_hdr_pack(CTRL_MAGIC, bus.cfg_stage_id, bus.cfg_res_id, bus.cfg_index,
                                          r_seq, {6'd0, w_cnt_eff})) :
              w_data_beat ? r_payload[32'(w_k_nxt)*W +: W] : '0;
    w_tuser = w_tvalid ? U'({SRC_PORT, w_len}) : '0;
    w_tkeep = w_tvalid ? '1 : '0;
    w_tlast = w_data_beat && w_k_nxt == r_cnt - 2'd1;
  end
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      r_tvalid <= 1'b0;
      r_tlast <= 1'b0;
      r_tdata <= '0;
      r_tuser <= '0;
      r_tkeep <= '0;
      r_cnt <= 2'd0;
      r_k <= 2'd0;
      r_seq <= 8'd0;
      r_gap <= 8'd0;
      r_pkt_cnt <= 32'd0;
      r_payload <= '0;
    end else begin
      r_tvalid <= w_tvalid;
      r_tlast <= w_tlast;
      r_tdata <= w_tdata;
      r_tuser <= w_tuser;
      r_tkeep <= w_tkeep;
      r_gap <= r_state == GAP ? r_gap + 8'd1 : 8'd0;
      if (w_accept) begin
        r_cnt <= w_cnt_eff;
        r_payload <= bus.cfg_payload;
      end
      if (w_data_beat) r_k <= w_k_nxt;
      if (w_last) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
        r_seq <= r_seq + 8'd1;
      end
    end
  end
  assign bus.cfg_req_ready = r_state == IDLE;
  assign bus.c_m_axis_tdata = r_tdata;
  assign bus.c_m_axis_tuser = r_tuser;
  assign bus.c_m_axis_tkeep = r_tkeep;
  assign bus.c_m_axis_tvalid = r_tvalid;
  assign bus.c_m_axis_tlast = r_tlast;
  assign busy = r_state != IDLE;
  assign pkt_cnt = r_pkt_cnt;
endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// tb_ctrl_pkt_gen: randomized self-checking bench for ctrl_pkt_gen against a packet-level reference model
module tb_ctrl_pkt_gen;
  localparam int W = 512;
  localparam int U = 128;
  localparam int MB = 2;
  localparam int GAP = 2;
  typedef struct {int cyc; logic [W-1:0] d; logic [U-1:0] u; logic l;} beat_t;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic busy, busy_z;
  logic [31:0] pkt_cnt, pkt_cnt_z;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int zero_viol = 0;
  int keep_viol = 0;
  bit rdy_log [0:16383];
  beat_t got[$], got_z[$], exp_q[$];
  logic [7:0] m_seq;
  int m_cnt;
  ctrl_pkt_gen_if #(.DATA_W(W), .USER_W(U), .MAX_BEATS(MB)) bus ();
  ctrl_pkt_gen_if #(.DATA_W(W), .USER_W(U), .MAX_BEATS(MB)) bz ();
  ctrl_pkt_gen #(.GAP_CYCLES(GAP)) dut (.axis_clk(clk), .aresetn(aresetn), .bus(bus.master), .busy(busy), .pkt_cnt(pkt_cnt));
  ctrl_pkt_gen #(.GAP_CYCLES(0)) dut_z (.axis_clk(clk), .aresetn(aresetn), .bus(bz.master), .busy(busy_z), .pkt_cnt(pkt_cnt_z));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    rdy_log[cyc % 16384] = bus.cfg_req_ready;
    if (bus.c_m_axis_tvalid === 1'b1) begin
      got.push_back('{cyc, bus.c_m_axis_tdata, bus.c_m_axis_tuser, bus.c_m_axis_tlast});
      if (bus.c_m_axis_tkeep !== '1) keep_viol++;
    end else if (bus.c_m_axis_tdata !== '0 || bus.c_m_axis_tuser !== '0 || bus.c_m_axis_tkeep !== '0 || bus.c_m_axis_tlast !== 1'b0)
      zero_viol++;
    if (bz.c_m_axis_tvalid === 1'b1) got_z.push_back('{cyc, bz.c_m_axis_tdata, bz.c_m_axis_tuser, bz.c_m_axis_tlast});
  end

  function automatic logic [2*W-1:0] rnd_pl();
    logic [2*W-1:0] r;
    for (int i = 0; i < 2*W/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Reference: one header beat then n payload beats at consecutive cycles, n clamped to 1..MB.
  task automatic model_pkt(input logic [4:0] st, input logic [2:0] rs, input logic [7:0] ix, input logic [1:0] nb,
                           input logic [2*W-1:0] pl, input int hcyc, output int last_cyc);
    int n;
    logic [W-1:0] h;
    logic [U-1:0] u;
    n = nb == 0 ? 1 : (int'(nb) > MB ? MB : int'(nb));
    h = '0;
    h[7:0] = 8'hF2;
    h[15:8] = st * 8 + rs;
    h[23:16] = ix;
    h[31:24] = m_seq;
    h[39:32] = 8'(n);
    u = '0;
    u[15:0] = 16'((1 + n) * (W / 8));
    exp_q.push_back('{hcyc, h, u, 1'b0});
    for (int j = 0; j < n; j++) exp_q.push_back('{hcyc + 1 + j, pl[j*W +: W], u, j == n - 1});
    m_seq = m_seq + 8'd1;
    m_cnt++;
    last_cyc = hcyc + n;
  endtask

  task automatic send(input logic [4:0] st, input logic [2:0] rs, input logic [7:0] ix, input logic [1:0] nb,
                      input logic [2*W-1:0] pl, input bit hold, output int acc);
    int n = 0;
    bus.cfg_stage_id = st;
    bus.cfg_res_id = rs;
    bus.cfg_index = ix;
    bus.cfg_nbeats = nb;
    bus.cfg_payload = pl;
    bus.cfg_req_valid = 1'b1;
    while (bus.cfg_req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = n < 100 ? cyc : -1000;
    @(posedge clk);
    #1;
    if (!hold) bus.cfg_req_valid = 1'b0;
  endtask

  task automatic wait_n(input int n);
    int t = 0;
    while (got.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    bus.cfg_req_valid = 1'b0;
    bz.cfg_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    m_seq = 8'd0;
    m_cnt = 0;
    @(negedge clk);
    got.delete();
    got_z.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    checks += 8;
    if (bus.c_m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", bus.c_m_axis_tvalid); end
    if (bus.c_m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", bus.c_m_axis_tlast); end
    if (bus.c_m_axis_tdata !== '0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", bus.c_m_axis_tdata[63:0]); end
    if (bus.c_m_axis_tuser !== '0) begin failures++; $display("FAIL reset_tuser got=%h exp=0", bus.c_m_axis_tuser); end
    if (bus.c_m_axis_tkeep !== '0) begin failures++; $display("FAIL reset_tkeep got=%h exp=0", bus.c_m_axis_tkeep); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (pkt_cnt !== 32'd0) begin failures++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
    if (bus.cfg_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.cfg_req_ready); end
  endtask

  task automatic test_single();
    int acc, lc;
    logic [2*W-1:0] pl;
    pl = rnd_pl();
    pl[W-1:0] = 512'hA5;
    send(5'd2, 3'd3, 8'h15, 2'd1, pl, 1'b0, acc);
    model_pkt(5'd2, 3'd3, 8'h15, 2'd1, pl, acc + 1, lc);
    wait_n(2);
    checks++;
    if (got.size() !== exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].u !== exp_q[i].u || got[i].l !== exp_q[i].l || got[i].cyc !== exp_q[i].cyc) begin
        failures++;
        $display("FAIL single_beat%0d cyc=%0d/%0d last=%b/%b user=%h/%h data=%h/%h", i, got[i].cyc, exp_q[i].cyc,
                 got[i].l, exp_q[i].l, got[i].u, exp_q[i].u, got[i].d[127:0], exp_q[i].d[127:0]);
      end
    end
    if (got.size() > 0) begin
      checks += 2;
      if (got[0].d[39:0] !== 40'h01_00_15_13_F2) begin failures++; $display("FAIL single_hdr got=%h exp=0100151 3f2", got[0].d[39:0]); end
      if (got[0].u[15:0] !== 16'd128) begin failures++; $display("FAIL single_len got=%0d exp=128", got[0].u[15:0]); end
    end
    checks += 4;
    if (rdy_log[(lc + 1) % 16384] !== 1'b0 || rdy_log[(lc + 2) % 16384] !== 1'b0) begin failures++; $display("FAIL single_gap_ready got=%b%b exp=00", rdy_log[(lc + 1) % 16384], rdy_log[(lc + 2) % 16384]); end
    if (rdy_log[(lc + 3) % 16384] !== 1'b1) begin failures++; $display("FAIL single_ready_back got=%b exp=1", rdy_log[(lc + 3) % 16384]); end
    if (pkt_cnt !== 32'd1) begin failures++; $display("FAIL single_pkt_cnt got=%0d exp=1", pkt_cnt); end
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
  endtask

  task automatic test_two_beat();
    int acc, lc;
    logic [2*W-1:0] pl;
    logic [4:0] st;
    logic [2:0] rs;
    logic [7:0] ix;
    got.delete();
    exp_q.delete();
    pl = rnd_pl();
    st = 5'($urandom_range(0, 4));
    rs = 3'($urandom_range(0, 3));
    ix = 8'($urandom());
    send(st, rs, ix, 2'd2, pl, 1'b0, acc);
    model_pkt(st, rs, ix, 2'd2, pl, acc + 1, lc);
    wait_n(3);
    checks++;
    if (got.size() !== 3) begin failures++; $display("FAIL two_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].u !== exp_q[i].u || got[i].l !== exp_q[i].l || got[i].cyc !== exp_q[i].cyc) begin
        failures++;
        $display("FAIL two_beat%0d cyc=%0d/%0d last=%b/%b user=%h/%h data=%h/%h", i, got[i].cyc, exp_q[i].cyc,
                 got[i].l, exp_q[i].l, got[i].u, exp_q[i].u, got[i].d[127:0], exp_q[i].d[127:0]);
      end
    end
    if (got.size() == 3) begin
      checks += 2;
      if (got[1].u[15:0] !== 16'd192) begin failures++; $display("FAIL two_len got=%0d exp=192", got[1].u[15:0]); end
      if (got[2].d !== pl[2*W-1:W]) begin failures++; $display("FAIL two_upper got=%h exp=%h", got[2].d[63:0], pl[W +: 64]); end
    end
  endtask

  task automatic test_clamp();
    int acc, lc;
    logic [2*W-1:0] pl;
    logic [1:0] nbs [2];
    nbs[0] = 2'd0;
    nbs[1] = 2'd3;
    for (int p = 0; p < 2; p++) begin
      got.delete();
      exp_q.delete();
      pl = rnd_pl();
      send(5'd1, 3'd2, 8'(p + 7), nbs[p], pl, 1'b0, acc);
      model_pkt(5'd1, 3'd2, 8'(p + 7), nbs[p], pl, acc + 1, lc);
      wait_n(exp_q.size());
      checks++;
      if (got.size() !== exp_q.size()) begin failures++; $display("FAIL clamp%0d_count got=%0d exp=%0d", p, got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        checks++;
        if (got[i].d !== exp_q[i].d || got[i].u !== exp_q[i].u || got[i].l !== exp_q[i].l || got[i].cyc !== exp_q[i].cyc) begin
          failures++;
          $display("FAIL clamp%0d_beat%0d cyc=%0d/%0d last=%b/%b user=%h/%h data=%h/%h", p, i, got[i].cyc, exp_q[i].cyc,
                   got[i].l, exp_q[i].l, got[i].u, exp_q[i].u, got[i].d[127:0], exp_q[i].d[127:0]);
        end
      end
      if (got.size() > 0) begin
        checks++;
        if (got[0].d[39:32] !== 8'(p + 1)) begin failures++; $display("FAIL clamp%0d_hdr_count got=%0d exp=%0d", p, got[0].d[39:32], p + 1); end
      end
    end
  endtask

  task automatic test_gap0();
    int n = 0;
    bz.cfg_stage_id = 5'd3;
    bz.cfg_res_id = 3'd1;
    bz.cfg_index = 8'h40;
    bz.cfg_nbeats = 2'd1;
    bz.cfg_payload = rnd_pl();
    bz.cfg_req_valid = 1'b1;
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (bz.cfg_req_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      bz.cfg_nbeats = 2'd2;
    end
    bz.cfg_req_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (got_z.size() !== 5) begin failures++; $display("FAIL gap0_count got=%0d exp=5", got_z.size()); end
    if (got_z.size() == 5) begin
      checks += 4;
      if (got_z[1].l !== 1'b1) begin failures++; $display("FAIL gap0_tlast got=%b exp=1", got_z[1].l); end
      if (got_z[2].cyc !== got_z[1].cyc + 2) begin failures++; $display("FAIL gap0_spacing got=%0d exp=2", got_z[2].cyc - got_z[1].cyc); end
      if (got_z[2].d[39:0] !== {8'd2, 8'd1, 8'h40, 8'h19, 8'hF2}) begin failures++; $display("FAIL gap0_hdr got=%h exp=0201401 9f2", got_z[2].d[39:0]); end
      if (pkt_cnt_z !== 32'd2) begin failures++; $display("FAIL gap0_pkt_cnt got=%0d exp=2", pkt_cnt_z); end
    end
  endtask

  task automatic test_back_to_back();
    int acc, lc, hc;
    int hpos [300];
    int hcy [300];
    int lcy [300];
    logic [2*W-1:0] pl;
    logic [4:0] st;
    logic [2:0] rs;
    logic [7:0] ix;
    logic [1:0] nb;
    do_reset();
    lc = 0;
    for (int i = 0; i < 300; i++) begin
      pl = rnd_pl();
      st = 5'($urandom_range(0, 31));
      rs = 3'($urandom_range(0, 7));
      ix = 8'($urandom());
      nb = 2'($urandom_range(0, 3));
      send(st, rs, ix, nb, pl, 1'b1, acc);
      hc = i == 0 ? acc + 1 : lc + GAP + 2;
      hpos[i] = exp_q.size();
      hcy[i] = hc;
      model_pkt(st, rs, ix, nb, pl, hc, lc);
      lcy[i] = lc;
    end
    bus.cfg_req_valid = 1'b0;
    wait_n(exp_q.size());
    checks++;
    if (got.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].u !== exp_q[i].u || got[i].l !== exp_q[i].l || got[i].cyc !== exp_q[i].cyc) begin
        failures++;
        $display("FAIL b2b_beat%0d cyc=%0d/%0d last=%b/%b user=%h/%h data=%h/%h", i, got[i].cyc, exp_q[i].cyc,
                 got[i].l, exp_q[i].l, got[i].u, exp_q[i].u, got[i].d[127:0], exp_q[i].d[127:0]);
      end
    end
    for (int i = 0; i < 300; i++) begin
      bit bad = 1'b0;
      for (int c = hcy[i]; c <= lcy[i] + GAP; c++) if (rdy_log[c % 16384] !== 1'b0) bad = 1'b1;
      if (rdy_log[(lcy[i] + GAP + 1) % 16384] !== 1'b1) bad = 1'b1;
      checks++;
      if (bad) begin failures++; $display("FAIL b2b_ready pkt=%0d hdr_cyc=%0d last_cyc=%0d", i, hcy[i], lcy[i]); end
    end
    if (got.size() > hpos[299]) begin
      checks += 2;
      if (got[hpos[255]].d[31:24] !== 8'd255) begin failures++; $display("FAIL b2b_seq255 got=%0d exp=255", got[hpos[255]].d[31:24]); end
      if (got[hpos[256]].d[31:24] !== 8'd0) begin failures++; $display("FAIL b2b_seq_wrap got=%0d exp=0", got[hpos[256]].d[31:24]); end
    end
    checks++;
    if (pkt_cnt !== 32'(m_cnt)) begin failures++; $display("FAIL b2b_pkt_cnt got=%0d exp=%0d", pkt_cnt, m_cnt); end
  endtask

  task automatic test_reset_mid();
    int acc, lc, t;
    logic [2*W-1:0] pl;
    pl = rnd_pl();
    send(5'd0, 3'd1, 8'h33, 2'd2, pl, 1'b0, acc);
    t = 0;
    while (cyc < acc + 3 && t < 20) begin
      @(negedge clk);
      t++;
    end
    aresetn = 1'b0;
    @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    checks += 4;
    if (bus.c_m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_tvalid got=%b exp=0", bus.c_m_axis_tvalid); end
    if (bus.c_m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_mid_tlast got=%b exp=0", bus.c_m_axis_tlast); end
    if (pkt_cnt !== 32'd0) begin failures++; $display("FAIL rst_mid_pkt_cnt got=%0d exp=0", pkt_cnt); end
    if (bus.cfg_req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", bus.cfg_req_ready); end
    m_seq = 8'd0;
    m_cnt = 0;
    got.delete();
    exp_q.delete();
    pl = rnd_pl();
    send(5'd4, 3'd0, 8'h99, 2'd1, pl, 1'b0, acc);
    model_pkt(5'd4, 3'd0, 8'h99, 2'd1, pl, acc + 1, lc);
    wait_n(2);
    checks++;
    if (got.size() !== 2) begin failures++; $display("FAIL rst_mid_count got=%0d exp=2", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].u !== exp_q[i].u || got[i].l !== exp_q[i].l || got[i].cyc !== exp_q[i].cyc) begin
        failures++;
        $display("FAIL rst_mid_beat%0d cyc=%0d/%0d last=%b/%b data=%h/%h", i, got[i].cyc, exp_q[i].cyc,
                 got[i].l, exp_q[i].l, got[i].d[63:0], exp_q[i].d[63:0]);
      end
    end
    checks++;
    if (pkt_cnt !== 32'd1) begin failures++; $display("FAIL rst_mid_pkt_cnt_after got=%0d exp=1", pkt_cnt); end
  endtask

  task automatic test_idle_zero();
    checks += 2;
    if (zero_viol !== 0) begin failures++; $display("FAIL idle_zero got=%0d exp=0", zero_viol); end
    if (keep_viol !== 0) begin failures++; $display("FAIL tkeep_ones got=%0d exp=0", keep_viol); end
  endtask

  initial begin
    bus.cfg_req_valid = 1'b0;
    bus.cfg_stage_id = '0;
    bus.cfg_res_id = '0;
    bus.cfg_index = '0;
    bus.cfg_nbeats = '0;
    bus.cfg_payload = '0;
    bz.cfg_req_valid = 1'b0;
    bz.cfg_stage_id = '0;
    bz.cfg_res_id = '0;
    bz.cfg_index = '0;
    bz.cfg_nbeats = '0;
    bz.cfg_payload = '0;
    do_reset();
    test_reset();
    test_single();
    test_two_beat();
    test_clamp();
    test_gap0();
    test_back_to_back();
    test_reset_mid();
    test_idle_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
